// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// and a small shift-register instruction buffer feeding decode.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic {
      S_FETCH,
      S_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   data_q [FIFO_DEPTH];
   logic [31:0]   data_d [FIFO_DEPTH];
   logic [31:0]   ipc_q  [FIFO_DEPTH];
   logic [31:0]   ipc_d  [FIFO_DEPTH];

   logic          push;
   logic          pop;
   logic [CW-1:0] widx;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      count_d    = count_q;
      data_d     = data_q;
      ipc_d      = ipc_q;
      imem_req   = 1'b0;
      imem_addr  = pc_q;
      push       = 1'b0;
      pop        = (count_q != '0) && inst_ready && !redirect_valid;

      case (state_q)
         S_FETCH: begin
            imem_req = !rst && (count_q < DEPTH_C) && !redirect_valid;
            if (imem_req && imem_gnt) begin
               fetch_pc_d = pc_q;
               pc_d       = pc_q + 32'd4;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               push      = !discard_q && !redirect_valid;
               discard_d = 1'b0;
               state_d   = S_FETCH;
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = S_FETCH;
      endcase

      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end

      // Head lives in slot 0; a pop that empties the buffer leaves slot 0
      // untouched so the outputs hold their last values.
      widx = pop ? (count_q - ONE_C) : count_q;
      if (pop && (count_q > ONE_C)) begin
         for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
            data_d[i] = data_q[i+1];
            ipc_d[i]  = ipc_q[i+1];
         end
      end
      if (push) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) == widx) begin
               data_d[i] = imem_rdata;
               ipc_d[i]  = fetch_pc_q;
            end
         end
      end

      if (redirect_valid) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + ONE_C;
      end else if (pop && !push) begin
         count_d = count_q - ONE_C;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         fetch_pc_q <= '0;
         discard_q  <= 1'b0;
         count_q    <= '0;
         data_q     <= '{default: '0};
         ipc_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         data_q     <= data_d;
         ipc_q      <= ipc_d;
      end
   end

   assign inst_valid = (count_q != '0);
   assign inst_data  = data_q[0];
   assign inst_pc    = ipc_q[0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed per-cycle vector bench for ifetch_unit, plus an async-reset sequence.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ifetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   typedef struct {
      bit          rb;     // pulse reset before this vector
      bit          gnt;
      bit          rv;
      logic [31:0] rdata;
      bit          rdr;
      logic [31:0] rpc;
      bit          rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_iv;
      logic [31:0] e_data;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(bit rb, bit g, bit rv, logic [31:0] rd, bit rr,
                               logic [31:0] rp, bit rdy, bit er, logic [31:0] ea,
                               bit ei, logic [31:0] ed, logic [31:0] ep);
      vec_t v;
      v.rb = rb; v.gnt = g; v.rv = rv; v.rdata = rd; v.rdr = rr; v.rpc = rp;
      v.rdy = rdy; v.e_req = er; v.e_addr = ea; v.e_iv = ei; v.e_data = ed;
      v.e_pc = ep;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit g, input bit rv, input logic [31:0] rd,
                        input bit rr, input logic [31:0] rp, input bit rdy);
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rd;
      redirect_valid = rr;
      redirect_pc    = rp;
      inst_ready     = rdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, '0, 0, '0, 0);
      #1;
      chk("reset req",   32'(imem_req),   32'h0);
      chk("reset valid", 32'(inst_valid), 32'h0);
      chk("reset data",  inst_data,       32'h0);
      chk("reset pc",    inst_pc,         32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Streaming, gnt always 1, rvalid one cycle later, rdata = addr ^ A5A5_0000.
      vq.push_back(mk(1,1,0,32'h0,0,32'h0,1, 1,32'h0,   0,32'h0,0));
      vq.push_back(mk(0,1,1,32'hA5A5_0000,0,32'h0,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'h4,   1,32'hA5A5_0000,32'h0));
      vq.push_back(mk(0,1,1,32'hA5A5_0004,0,32'h0,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'h8,   1,32'hA5A5_0004,32'h4));
      vq.push_back(mk(0,1,1,32'hA5A5_0008,0,32'h0,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,1, 1,32'hC,   1,32'hA5A5_0008,32'h8));
      // Redirect while waiting on the 0x8 response.
      vq.push_back(mk(1,1,0,32'h0,0,32'h0,0, 1,32'h0,   0,32'h0,0));
      vq.push_back(mk(0,0,1,32'h1111_0000,0,32'h0,0, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,0, 1,32'h4,   1,32'h1111_0000,32'h0));
      vq.push_back(mk(0,0,1,32'h1111_0004,0,32'h0,1, 0,32'h0, 1,32'h1111_0000,32'h0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'h8,   1,32'h1111_0004,32'h4));
      vq.push_back(mk(0,0,0,32'h0,1,32'h100,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,0,1,32'h1111_0008,0,32'h0,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'h100, 0,32'h0,0));
      vq.push_back(mk(0,0,1,32'hCAFE_0100,0,32'h0,0, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,0, 1,32'h104, 1,32'hCAFE_0100,32'h100));
      // Redirect coincident with rvalid and a pop; unaligned target 0x203.
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,0, 1,32'h104, 1,32'hCAFE_0100,32'h100));
      vq.push_back(mk(0,0,1,32'hDEAD_0104,1,32'h203,1, 0,32'h0, 1,32'hCAFE_0100,32'h100));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,1, 1,32'h200, 0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'h200, 0,32'h0,0));
      vq.push_back(mk(0,0,1,32'h5A5A_0200,0,32'h0,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,1, 1,32'h204, 1,32'h5A5A_0200,32'h200));
      // Grant withheld, then redirect to the top word and wrap to 0.
      vq.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h0,   0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,1, 1,32'h0,   0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,1, 1,32'h0,   0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'h0,   0,32'h0,0));
      vq.push_back(mk(0,0,1,32'h7777_0000,0,32'h0,0, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,1,32'hFFFF_FFFC,1, 0,32'h0, 1,32'h7777_0000,32'h0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'hFFFF_FFFC, 0,32'h0,0));
      vq.push_back(mk(0,0,1,32'h1234_FFFC,0,32'h0,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,1, 1,32'h0,   1,32'h1234_FFFC,32'hFFFF_FFFC));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,0, 1,32'h0,   0,32'h0,0));
      // Backpressure fills both entries, drain, then back-to-back redirects.
      vq.push_back(mk(1,1,0,32'h0,0,32'h0,0, 1,32'h0,   0,32'h0,0));
      vq.push_back(mk(0,0,1,32'hB0B0_0000,0,32'h0,0, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,0, 1,32'h4,   1,32'hB0B0_0000,32'h0));
      vq.push_back(mk(0,0,1,32'hB0B0_0004,0,32'h0,0, 0,32'h0, 1,32'hB0B0_0000,32'h0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,0, 0,32'h0,   1,32'hB0B0_0000,32'h0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,0, 0,32'h0,   1,32'hB0B0_0000,32'h0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,1, 0,32'h0,   1,32'hB0B0_0000,32'h0));
      vq.push_back(mk(0,1,0,32'h0,0,32'h0,1, 1,32'h8,   1,32'hB0B0_0004,32'h4));
      vq.push_back(mk(0,0,1,32'hB0B0_0008,0,32'h0,1, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,0, 1,32'hC,   1,32'hB0B0_0008,32'h8));
      vq.push_back(mk(0,0,0,32'h0,1,32'h400,0, 0,32'h0, 1,32'hB0B0_0008,32'h8));
      vq.push_back(mk(0,0,0,32'h0,1,32'h500,0, 0,32'h0, 0,32'h0,0));
      vq.push_back(mk(0,0,0,32'h0,0,32'h0,0, 1,32'h500, 0,32'h0,0));

      foreach (vq[i]) begin
         if (vq[i].rb) do_reset();
         @(negedge clk);
         drive(vq[i].gnt, vq[i].rv, vq[i].rdata, vq[i].rdr, vq[i].rpc, vq[i].rdy);
         #1;
         chk($sformatf("v%0d req", i), 32'(imem_req), 32'(vq[i].e_req));
         if (vq[i].e_req) chk($sformatf("v%0d addr", i), imem_addr, vq[i].e_addr);
         chk($sformatf("v%0d valid", i), 32'(inst_valid), 32'(vq[i].e_iv));
         if (vq[i].e_iv) begin
            chk($sformatf("v%0d data", i), inst_data, vq[i].e_data);
            chk($sformatf("v%0d pc", i), inst_pc, vq[i].e_pc);
         end
      end

      // Asynchronous reset while waiting with one entry buffered.
      do_reset();
      @(negedge clk); drive(1, 0, '0, 0, '0, 0);
      @(negedge clk); drive(0, 1, 32'h9999_0000, 0, '0, 0);
      @(negedge clk); drive(1, 0, '0, 0, '0, 0);
      @(negedge clk); drive(0, 0, '0, 0, '0, 0);
      #1;
      chk("pre-rst valid", 32'(inst_valid), 32'h1);
      chk("pre-rst pc", inst_pc, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst valid", 32'(inst_valid), 32'h0);
      chk("async rst req",   32'(imem_req),   32'h0);
      chk("async rst data",  inst_data,       32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 32'hDEAD_BEEF, 0, '0, 0);
      #1;
      chk("post-rst req",  32'(imem_req), 32'h1);
      chk("post-rst addr", imem_addr,     32'h0);
      @(negedge clk); drive(1, 0, '0, 0, '0, 1);
      #1;
      chk("stray rvalid valid", 32'(inst_valid), 32'h0);
      chk("post-rst req2",  32'(imem_req), 32'h1);
      chk("post-rst addr2", imem_addr,     32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction field decoder.
- Holds the PC and issues word fetches to the instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents {inst_data, inst_pc} to decode with a valid/ready handshake.
- Redirects from branch/jump resolution flush the FIFO and discard any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; legal values are 2 or 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch byte address; bits [1:0] are always 0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; at most one response per granted request, arriving at least 1 cycle after grant.
- imem_rdata  input  32  fetched instruction word.
- redirect_valid  input  1  control-flow change.
- redirect_pc  input  32  new PC; bits [1:0] are ignored and treated as 0.
- inst_valid  output  1  FIFO head is valid.
- inst_ready  input  1  decode accepts the head.
- inst_data  output  32  head instruction word, which feeds the decoder's inst_data input.
- inst_pc  output  32  PC of the head instruction.

Behaviour:
- Reset (asynchronous, rst=1):
  - pc=RESET_PC, state=FETCH, FIFO count=0, discard=0.
  - imem_req=0, inst_valid=0, inst_data=0, inst_pc=0.
- State machine FETCH / WAIT, with at most one outstanding request.
- FETCH:
  - imem_req = (count < FIFO_DEPTH) and not redirect_valid; imem_addr = pc.
  - On imem_req && imem_gnt: fetch_pc <= pc, pc <= pc+4 (wraps mod 2^32), go to WAIT.
  - imem_req and imem_addr stay stable until granted.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: if discard=0, push {imem_rdata, fetch_pc}; clear discard; go to FETCH.
- Redirect (redirect_valid=1) takes priority over every other event in the same cycle:
  - pc <= {redirect_pc[31:2], 2'b00}; FIFO flushed (count=0).
  - Any same-cycle pop is ignored.
  - In FETCH, imem_req is forced to 0 that cycle, so no grant can coincide with a redirect.
  - In WAIT without a same-cycle rvalid: discard <= 1 and stay in WAIT; the response is dropped when it arrives, then go to FETCH.
  - In WAIT with a same-cycle rvalid: that data is dropped, discard stays 0, go to FETCH.
  - Back-to-back redirects: the last one wins.
- FIFO:
  - Registered storage; head is driven from registers.
  - inst_valid = (count != 0).
  - Pop on inst_valid && inst_ready; push and pop may occur in the same cycle.
  - Overflow is impossible because a request issues only when count < FIFO_DEPTH and pops only reduce count. No push ever occurs when full.
  - When empty, inst_data and inst_pc hold their last values and inst_valid=0.
- Latency:
  - Grant at cycle N, rvalid at N+1, inst_valid at N+2.
  - Sustained throughput is 1 instruction per 2 cycles with 1-cycle memory latency.
- inst_data and inst_pc remain stable while inst_valid && !inst_ready, unless a redirect occurs.
- Reset asserted mid-transaction: all state clears immediately. Any response arriving after reset release while in FETCH is ignored (rvalid is only honoured in WAIT).

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000, inst_ready=1:
  - imem_addr sequence is 0x0, 0x4, 0x8.
  - inst_pc sequence is 0x0, 0x4, 0x8, with inst_data matching rdata for each.
- Backpressure, inst_ready=0, FIFO_DEPTH=2:
  - Exactly 2 requests (0x0, 0x4) are granted, then imem_req stays 0.
  - Head holds pc 0x0.
  - After inst_ready=1, the 0x0 and 0x4 entries drain in order and fetch resumes at 0x8.
- Redirect while in WAIT:
  - Sequence: gnt for 0x8, then redirect_pc=0x100 the next cycle, then rvalid the cycle after.
  - The 0x8 data is never presented; the next imem_addr is 0x100.
  - The first inst_pc after the redirect is 0x100.
- Redirect coincident with rvalid and with a pop:
  - FIFO ends empty and the rvalid data is dropped.
  - Next fetch is redirect_pc=0x203, issued as imem_addr=0x200.
- gnt withheld for 3 cycles while in FETCH: imem_req and imem_addr stay at 0x0 with no PC advance. Wrap case: redirect to 0xFFFF_FFFC, then the next fetch is 0x0.
- rst pulsed asynchronously while in WAIT with 1 entry buffered:
  - inst_valid and imem_req drop to 0 immediately.
  - After release, the next request is to RESET_PC.
